// File: rtl/id4s_result_capture.sv
// ID4s result capture stage.
// Follows each operand pair launched into the 4-bit divider through its fixed
// latency. Samples Q/R on the edge where that pair's result is valid. Queues
// tagged results in a show-ahead FIFO for a ready/valid consumer, and counts
// results lost because the FIFO was full.
module id4s_result_capture #(
    parameter int LAT   = 6,
    parameter int DEPTH = 4,
    parameter int SEQW  = 4
) (
    input  logic            GCLK,
    input  logic            GRST_N,
    input  logic            issue,
    input  logic            issue_dz,
    input  logic [3:0]      Q,
    input  logic [3:0]      R,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_q,
    output logic [3:0]      out_r,
    output logic            out_dz,
    output logic [SEQW-1:0] out_seq,
    output logic [7:0]      drop_cnt,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]      q;
        logic [3:0]      r;
        logic            dz;
        logic [SEQW-1:0] seq;
    } entry_t;

    // Tag pipe: one {v, dz, seq} per divider stage; index LAT-1 is the head.
    logic [LAT-1:0]  tag_v_q;
    logic [LAT-1:0]  tag_dz_q;
    logic [SEQW-1:0] tag_seq_q [LAT];
    logic [SEQW-1:0] seq_cnt_q, seq_cnt_d;

    // Result FIFO. Each pointer carries one extra bit to tell full from empty.
    entry_t          mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            head_v;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;
    entry_t          cap_entry;
    entry_t          head_entry;

    assign head_v     = tag_v_q[LAT-1];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // out_valid comes from registered pointers only, so out_ready never reaches it.
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign push       = head_v && (!fifo_full || pop);
    assign drop       = head_v && fifo_full && !pop;

    // A zero-divisor result carries no meaningful quotient or remainder.
    assign cap_entry.q   = tag_dz_q[LAT-1] ? 4'h0 : Q;
    assign cap_entry.r   = tag_dz_q[LAT-1] ? 4'h0 : R;
    assign cap_entry.dz  = tag_dz_q[LAT-1];
    assign cap_entry.seq = tag_seq_q[LAT-1];

    // Head fields are gated by out_valid so that unwritten storage never shows on the outputs.
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign out_q      = out_valid ? head_entry.q   : 4'h0;
    assign out_r      = out_valid ? head_entry.r   : 4'h0;
    assign out_dz     = out_valid ? head_entry.dz  : 1'b0;
    assign out_seq    = out_valid ? head_entry.seq : '0;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (|tag_v_q) || !fifo_empty;

    // Next-state for the sequence counter, the FIFO pointers and the saturating drop counter.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the block can infer a latch.
        seq_cnt_d  = seq_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (issue) seq_cnt_d = seq_cnt_q + SEQW'(1);
        if (push)  wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
        if (pop)   rd_ptr_d  = rd_ptr_q + (AW+1)'(1);
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Shift the tag pipe and update the counters and pointers; reset drops everything in flight.
    always_ff @(posedge GCLK or negedge GRST_N) begin
        if (!GRST_N) begin
            tag_v_q    <= '0;
            tag_dz_q   <= '0;
            for (int i = 0; i < LAT; i++) tag_seq_q[i] <= '0;
            seq_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read the value it held before this edge.
            for (int i = LAT - 1; i > 0; i--) begin
                tag_v_q[i]   <= tag_v_q[i-1];
                tag_dz_q[i]  <= tag_dz_q[i-1];
                tag_seq_q[i] <= tag_seq_q[i-1];
            end
            tag_v_q[0]   <= issue;
            tag_dz_q[0]  <= issue_dz;
            tag_seq_q[0] <= seq_cnt_q;
            seq_cnt_q    <= seq_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Write the captured entry into the FIFO storage.
    always_ff @(posedge GCLK) begin
        // NOTE: storage is not reset; the reset pointers mark it empty, and the outputs are gated by out_valid.
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cap_entry;
    end

endmodule

// File: tb/tb_id4s_result_capture.sv
// Testbench for id4s_result_capture.
// Each issue books the pad values for its capture edge. At that edge a FIFO
// model either queues the expected result or counts a drop. Every handshake
// pops the model and compares the result.
module tb_id4s_result_capture;

    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int SEQW  = 4;
    localparam int NCYC  = 2048;

    typedef struct packed {
        logic [3:0]      q;
        logic [3:0]      r;
        logic            dz;
        logic [SEQW-1:0] seq;
    } exp_t;

    logic            GCLK;
    logic            GRST_N;
    logic            issue;
    logic            issue_dz;
    logic [3:0]      Q;
    logic [3:0]      R;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_q;
    logic [3:0]      out_r;
    logic            out_dz;
    logic [SEQW-1:0] out_seq;
    logic [7:0]      drop_cnt;
    logic            busy;

    id4s_result_capture #(.LAT(LAT), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
        .GCLK      (GCLK),
        .GRST_N    (GRST_N),
        .issue     (issue),
        .issue_dz  (issue_dz),
        .Q         (Q),
        .R         (R),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dz    (out_dz),
        .out_seq   (out_seq),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    initial GCLK = 1'b0;
    always #5 GCLK = ~GCLK;

    int              total;
    int              bad;
    int              cyc;
    int              drop_m;
    logic [SEQW-1:0] seq_m;
    exp_t            fifo_m [$];
    bit              cap_v   [NCYC];
    exp_t            cap_exp [NCYC];
    logic [3:0]      pad_q   [NCYC];
    logic [3:0]      pad_r   [NCYC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_flight();
        bit f;
        f = 1'b0;
        for (int k = 0; k < LAT; k++) if (cap_v[cyc + k]) f = 1'b1;
        return f;
    endfunction

    // Drive one cycle, check the state left by the previous edge, then advance the model over the next edge.
    task automatic step(input bit iss, input bit dz, input bit rdy, input logic [3:0] pq, input logic [3:0] pr);
        bit   pop;
        exp_t e;
        issue     = iss;
        issue_dz  = dz;
        out_ready = rdy;
        if (iss) begin
            cap_v[cyc + LAT]   = 1'b1;
            pad_q[cyc + LAT]   = pq;
            pad_r[cyc + LAT]   = pr;
            e.q   = dz ? 4'h0 : pq;
            e.r   = dz ? 4'h0 : pr;
            e.dz  = dz;
            e.seq = seq_m;
            cap_exp[cyc + LAT] = e;
            seq_m = seq_m + 1'b1;
        end
        if (cap_v[cyc]) begin
            Q = pad_q[cyc];
            R = pad_r[cyc];
        end else begin
            Q = 4'($urandom_range(0, 15));
            R = 4'($urandom_range(0, 15));
        end
        #1;
        check("busy", busy, (fifo_m.size() != 0) || in_flight());
        check("out_valid", out_valid, fifo_m.size() != 0);
        check("drop_cnt", drop_cnt, drop_m);
        if (fifo_m.size() != 0) begin
            check("out_q", out_q, fifo_m[0].q);
            check("out_r", out_r, fifo_m[0].r);
            check("out_dz", out_dz, fifo_m[0].dz);
            check("out_seq", out_seq, fifo_m[0].seq);
        end
        pop = (fifo_m.size() != 0) && rdy;
        if (pop) void'(fifo_m.pop_front());
        if (cap_v[cyc]) begin
            if (fifo_m.size() < DEPTH) fifo_m.push_back(cap_exp[cyc]);
            else if (drop_m < 255) drop_m++;
        end
        @(posedge GCLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 4'h0, 4'h0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((fifo_m.size() != 0 || in_flight()) && i < 200) begin
            step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
            i++;
        end
        check("drain_done", (fifo_m.size() != 0 || in_flight()) ? 1 : 0, 0);
        idle(2, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        drop_m = 0;
        seq_m  = '0;
        for (int i = 0; i < NCYC; i++) cap_v[i] = 1'b0;
        GRST_N    = 1'b0;
        issue     = 1'b0;
        issue_dz  = 1'b0;
        out_ready = 1'b0;
        Q         = 4'h0;
        R         = 4'h0;
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_q", out_q, 0);
        check("rst_out_r", out_r, 0);
        check("rst_out_dz", out_dz, 0);
        check("rst_out_seq", out_seq, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(posedge GCLK);
        #1;
        GRST_N = 1'b1;

        // Single issue: the result appears one cycle after edge +LAT; pads on the other edges are noise.
        step(1'b1, 1'b0, 1'b0, 4'h3, 4'h1);
        idle(LAT, 1'b0);
        check("single_valid", out_valid, 1);
        check("single_q", out_q, 4'h3);
        check("single_r", out_r, 4'h1);
        check("single_seq", out_seq, 0);
        check("single_dz", out_dz, 0);
        drain();

        // Ten back-to-back issues while the consumer is always ready.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        drain();
        check("b2b_no_drop", drop_cnt, 0);

        // Back-pressure: six issues into a four-entry FIFO, so two results are dropped.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(LAT + 1, 1'b0);
        check("bp_drop_cnt", drop_cnt, 2);
        check("bp_head_seq", out_seq, 4'd11);
        drain();

        // Full FIFO, with a pop and a capture on the same edge.
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        idle(LAT, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'hC, 4'h7);
        idle(LAT - 1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        idle(3, 1'b0);
        check("swap_drop_cnt", drop_cnt, 2);
        check("swap_still_full", fifo_m.size(), DEPTH);
        drain();

        // Zero-divisor issue: the quotient and remainder are forced to zero.
        step(1'b1, 1'b1, 1'b0, 4'hF, 4'h9);
        idle(LAT, 1'b0);
        check("dz_flag", out_dz, 1);
        check("dz_q", out_q, 0);
        check("dz_r", out_r, 0);
        drain();

        // Reset mid-flight with 20 issues outstanding.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        issue = 1'b0;
        #2;
        GRST_N = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_q", out_q, 0);
        check("midrst_out_r", out_r, 0);
        check("midrst_out_dz", out_dz, 0);
        check("midrst_out_seq", out_seq, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        fifo_m.delete();
        for (int i = 0; i < NCYC; i++) cap_v[i] = 1'b0;
        seq_m  = '0;
        drop_m = 0;
        @(posedge GCLK);
        #1;
        cyc++;
        GRST_N = 1'b1;
        idle(LAT + 4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 4'h5, 4'h2);
        idle(LAT, 1'b0);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_seq", out_seq, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
